// File: rtl/wb_efb_arbiter.sv
// Two-master Wishbone arbiter for the EFB slave port.
// Round-robin with cyc lock and an ack-timeout watchdog.
module wb_efb_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int TO_CYC = 255
) (
    input  logic              xclk,
    input  logic              rst,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack,
    output logic              m1_err,

    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G0    = 2'd1,
        G1    = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

    state_t            state;
    state_t            nextState;
    logic              last;
    logic              nextLast;
    logic [1:0]        gntQ;
    logic [1:0]        nextGnt;
    logic [15:0]       timer;
    logic [DATA_W-1:0] rdData;

    logic              granted;
    logic              selM1;
    logic              ownCyc;
    logic              toHit;

    // Granted means a live Gn state; ABORT keeps gnt but not the bus.
    assign granted = (state == G0) || (state == G1);
    assign selM1   = (state == G1);
    assign ownCyc  = gntQ[1] ? m1_cyc : m0_cyc;

    // Timeout fires only while the owner still holds cyc and no ack arrives.
    assign toHit = granted && ownCyc && s_stb && !s_ack_i
                   && (timer == TO_LAST);

    assign gnt = gntQ;

    // Slave-side mux driven from the registered grant.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        if (granted) begin
            if (selM1) begin
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_o = m1_dat_i;
            end else begin
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_o = m0_dat_i;
            end
        end
    end

    // Ack and abort routing back to the owning master.
    always_comb begin
        m0_ack = s_ack_i && granted && !selM1;
        m1_ack = s_ack_i && granted && selM1;
        m0_err = toHit && !selM1;
        m1_err = toHit && selM1;
    end

    // Next-state, grant and round-robin pointer.
    always_comb begin
        nextState = state;
        nextLast  = last;
        nextGnt   = gntQ;
        unique case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    nextState = last ? G0 : G1;
                end else if (m0_cyc) begin
                    nextState = G0;
                end else if (m1_cyc) begin
                    nextState = G1;
                end
            end
            G0: begin
                if (!m0_cyc) begin
                    nextState = IDLE;
                end else if (toHit) begin
                    nextState = ABORT;
                end
            end
            G1: begin
                if (!m1_cyc) begin
                    nextState = IDLE;
                end else if (toHit) begin
                    nextState = ABORT;
                end
            end
            ABORT: begin
                if (!ownCyc) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase

        unique case (nextState)
            IDLE:    nextGnt = 2'b00;
            G0:      nextGnt = 2'b01;
            G1:      nextGnt = 2'b10;
            ABORT:   nextGnt = gntQ;
            default: nextGnt = 2'b00;
        endcase

        if (state == IDLE && nextState == G0) begin
            nextLast = 1'b0;
        end else if (state == IDLE && nextState == G1) begin
            nextLast = 1'b1;
        end
    end

    // State, grant and pointer registers.
    always_ff @(posedge xclk) begin
        if (rst) begin
            state <= IDLE;
            gntQ  <= 2'b00;
            last  <= 1'b1;
        end else begin
            state <= nextState;
            gntQ  <= nextGnt;
            last  <= nextLast;
        end
    end

    // Watchdog timer: counts stalled strobe cycles, saturating.
    always_ff @(posedge xclk) begin
        if (rst) begin
            timer <= '0;
        end else if (!granted || nextState != state
                     || s_ack_i || !s_stb) begin
            timer <= '0;
        end else if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
        end
    end

    // Read data capture on every slave ack.
    always_ff @(posedge xclk) begin
        if (rst) begin
            rdData <= '0;
        end else if (s_ack_i) begin
            rdData <= s_dat_i;
        end
    end

    assign m0_dat_o = rdData;
    assign m1_dat_o = rdData;

endmodule
